e203_dma_xfer_engine: RTL and testbench

Transfer engine placed directly downstream of the DMA configuration register block. It takes a latched source address, destination address and word count, plus a start pulse. It then moves the words from source to destination over a single ICB master port, using a chunked read-then-write scheme through a local FIFO. When finished it raises a one-cycle completion interrupt and an error flag, which the config block uses to clear its registers and report status.

---
 rtl/e203_dma_pkg.sv | 28 ++
 rtl/e203_dma_fifo.sv | 54 +++++
 rtl/e203_dma_xfer_engine.sv | 204 ++++++++++++++++++++
 tb/tb_e203_dma_xfer_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_dma_pkg.sv
// Shared definitions for the E203 DMA slice: FSM state encoding, address
// step, write mask and the default sizing used by both the configuration
// register block and the transfer engine.
package e203_dma_pkg;

  localparam int          DMA_BUF_DEPTH = 4;      // default FIFO depth / max chunk
  localparam int          DMA_LEN_W     = 16;     // default word-count width
  localparam logic [31:0] DMA_ADDR_STEP = 32'd4;  // bytes between consecutive words
  localparam logic [3:0]  WMASK_ALL     = 4'hF;   // full-word writes only

  // Transfer engine FSM encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD_CMD = 3'd1;
  localparam logic [2:0] ST_RD_RSP = 3'd2;
  localparam logic [2:0] ST_WR_CMD = 3'd3;
  localparam logic [2:0] ST_WR_RSP = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RD_CMD = ST_RD_CMD,
    S_RD_RSP = ST_RD_RSP,
    S_WR_CMD = ST_WR_CMD,
    S_WR_RSP = ST_WR_RSP,
    S_DONE   = ST_DONE
  } dma_state_e;

endpackage

// File: rtl/e203_dma_fifo.sv
// Synchronous BUF_DEPTH x 32 FIFO holding one chunk of read data between
// the read and write phases of the transfer engine.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, wdata write one word (ignored when full)
//   pop         drop the head word (ignored when empty)
//   flush       synchronous clear of both pointers
//   rdata       combinational head of the FIFO
//   empty, full occupancy flags
module e203_dma_fifo
  import e203_dma_pkg::*;
#(
  parameter int BUF_DEPTH = DMA_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        empty,
  output logic        full
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;  // extra bit tells full from empty

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem [BUF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PW'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/e203_dma_xfer_engine.sv
// DMA transfer engine. Copies len 32-bit words from src_addr to dst_addr over
// a single ICB master port, in chunks of up to BUF_DEPTH words: a chunk is
// read into the local FIFO, then written out, then the next chunk starts.
// Only one ICB command is ever outstanding.
//
// Build option: E203_DMA_XFER_ERR_ABORT_EN
//   defined   - a response error flushes the FIFO and ends the transfer
//   undefined - a response error is recorded in err and the copy continues
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, src_addr, dst_addr,
//   len                         transfer request (start sampled only in IDLE)
//   busy                        transfer in progress (low in IDLE)
//   done_irq                    one-cycle completion pulse
//   err                         sticky response-error flag
//   icb_cmd_*                   ICB command channel (master side)
//   icb_rsp_*                   ICB response channel (master side)
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; valid and all payload fields are held stable until that edge,
// and valid never depends combinationally on ready.
module e203_dma_xfer_engine
  import e203_dma_pkg::*;
#(
  parameter int          BUF_DEPTH = DMA_BUF_DEPTH,
  parameter int          LEN_W     = DMA_LEN_W,
  parameter logic [31:0] ADDR_STEP = DMA_ADDR_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done_irq,
  output logic             err,
  output logic             icb_cmd_valid,
  input  logic             icb_cmd_ready,
  output logic [31:0]      icb_cmd_addr,
  output logic             icb_cmd_read,
  output logic [31:0]      icb_cmd_wdata,
  output logic [3:0]       icb_cmd_wmask,
  input  logic             icb_rsp_valid,
  output logic             icb_rsp_ready,
  input  logic             icb_rsp_err,
  input  logic [31:0]      icb_rsp_rdata
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  dma_state_e       state, state_nxt;
  logic [31:0]      rd_ptr;
  logic [31:0]      wr_ptr;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] rem_dec;
  logic [CW-1:0]    chunk_left;   // reads still to issue in the current chunk

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic [31:0]      fifo_rdata;
  logic             fifo_empty;
  logic             fifo_full;

  function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] n);
    if (n >= LEN_W'(BUF_DEPTH)) return CW'(BUF_DEPTH);
    else                        return n[CW-1:0];
  endfunction

  assign rem_dec = remaining - LEN_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and FIFO controls
  always_comb begin
    state_nxt  = state;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (len != '0) ? S_RD_CMD : S_DONE;
      end
      S_RD_CMD: begin
        if (icb_cmd_ready) state_nxt = S_RD_RSP;
      end
      S_RD_RSP: begin
        if (icb_rsp_valid) begin
`ifdef E203_DMA_XFER_ERR_ABORT_EN
          if (icb_rsp_err) begin
            fifo_flush = 1'b1;
            state_nxt  = S_DONE;
          end else begin
            fifo_push = !fifo_full;
            state_nxt = (chunk_left != '0) ? S_RD_CMD : S_WR_CMD;
          end
`else
          // errored read data is still pushed and later written out
          fifo_push = !fifo_full;
          state_nxt = (chunk_left != '0) ? S_RD_CMD : S_WR_CMD;
`endif
        end
      end
      S_WR_CMD: begin
        if (icb_cmd_ready) begin
          fifo_pop  = 1'b1;
          state_nxt = S_WR_RSP;
        end
      end
      S_WR_RSP: begin
        if (icb_rsp_valid) begin
`ifdef E203_DMA_XFER_ERR_ABORT_EN
          if (icb_rsp_err) begin
            fifo_flush = 1'b1;
            state_nxt  = S_DONE;
          end else
`endif
          if (!fifo_empty)         state_nxt = S_WR_CMD;
          else if (rem_dec != '0)  state_nxt = S_RD_CMD;
          else                     state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address / length counters and the sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      remaining  <= '0;
      chunk_left <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (len != '0) begin
              rd_ptr     <= src_addr;
              wr_ptr     <= dst_addr;
              remaining  <= len;
              chunk_left <= chunk_of(len);
            end
          end
        end
        S_RD_CMD: begin
          if (icb_cmd_ready) begin
            rd_ptr     <= rd_ptr + ADDR_STEP;
            chunk_left <= chunk_left - CW'(1);
          end
        end
        S_RD_RSP: begin
          if (icb_rsp_valid && icb_rsp_err) err <= 1'b1;
        end
        S_WR_CMD: begin
          if (icb_cmd_ready) wr_ptr <= wr_ptr + ADDR_STEP;
        end
        S_WR_RSP: begin
          if (icb_rsp_valid) begin
            remaining <= rem_dec;
            if (icb_rsp_err) err <= 1'b1;
            // next chunk size is taken from the post-decrement count
            if (state_nxt == S_RD_CMD) chunk_left <= chunk_of(rem_dec);
          end
        end
        default: ;
      endcase
    end
  end

  e203_dma_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (icb_rsp_rdata),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Outputs are pure functions of state and registered counters, so command
  // fields cannot move while a command is stalled.
  assign busy          = (state != S_IDLE);
  assign done_irq      = (state == S_DONE);
  assign icb_cmd_valid = (state == S_RD_CMD) || (state == S_WR_CMD);
  assign icb_cmd_read  = (state == S_RD_CMD);
  assign icb_cmd_addr  = (state == S_RD_CMD) ? rd_ptr :
                         (state == S_WR_CMD) ? wr_ptr : 32'h0;
  assign icb_cmd_wdata = (state == S_WR_CMD) ? fifo_rdata : 32'h0;
  assign icb_cmd_wmask = WMASK_ALL;
  assign icb_rsp_ready = (state == S_RD_RSP) || (state == S_WR_RSP);

endmodule

// File: tb/tb_e203_dma_xfer_engine.sv
// Self-checking bench for e203_dma_xfer_engine. A behavioural ICB slave with
// a word memory answers the engine; the expected command stream of each
// transfer is derived from the chunked-copy rules and compared command by
// command.
module tb_e203_dma_xfer_engine;

  localparam int BUF   = 4;
  localparam int LEN_W = 16;

  // clock/reset and DUT signals
  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done_irq;
  logic             err;
  logic             icb_cmd_valid;
  logic             icb_cmd_ready;
  logic [31:0]      icb_cmd_addr;
  logic             icb_cmd_read;
  logic [31:0]      icb_cmd_wdata;
  logic [3:0]       icb_cmd_wmask;
  logic             icb_rsp_valid;
  logic             icb_rsp_ready;
  logic             icb_rsp_err;
  logic [31:0]      icb_rsp_rdata;

  e203_dma_xfer_engine #(.BUF_DEPTH(BUF), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .len           (len),
    .busy          (busy),
    .done_irq      (done_irq),
    .err           (err),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_err   (icb_rsp_err),
    .icb_rsp_rdata (icb_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {read, addr, wdata (0 for reads)}
  logic [64:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int checks   = 0;
  int failures = 0;

  // slave knobs and state
  int          stall_left   = 0;
  int          min_delay    = 0;
  int          max_delay    = 0;
  int          err_read_idx = 0;
  bit          rand_ready   = 0;
  int          rd_count     = 0;
  int          wr_accepts   = 0;
  bit          have_cmd     = 0;
  bit          cur_read     = 0;
  logic [31:0] cur_addr     = '0;
  int          rsp_wait     = 0;
  bit          stalled_prev = 0;
  logic [64:0] prev_fields  = '0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference: whole transfer as chunks of min(BUF, remaining) reads followed
  // by the same number of writes. With abort enabled the stream stops at the
  // errored read.
  function automatic void build_exp(input logic [31:0] src, input logic [31:0] dst,
                                    input int n, input int err_idx);
    int rem;
    int base;
    int c;
    exp_q.delete();
    rem  = n;
    base = 0;
    while (rem > 0) begin
      c = (rem < BUF) ? rem : BUF;
      for (int i = 0; i < c; i++) begin
        exp_q.push_back({1'b1, src + 32'(4 * (base + i)), 32'h0});
`ifdef E203_DMA_XFER_ERR_ABORT_EN
        if (base + i + 1 == err_idx) return;
`endif
      end
      for (int i = 0; i < c; i++)
        exp_q.push_back({1'b0, dst + 32'(4 * (base + i)), mem[src + 32'(4 * (base + i))]});
      base += c;
      rem  -= c;
    end
  endfunction

  // Behavioural ICB slave; decisions made on the falling edge take effect at
  // the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (have_cmd) check("one_outstanding", icb_cmd_valid, 1'b0);
      if (stalled_prev) begin
        check("stall_valid_held", icb_cmd_valid, 1'b1);
        check("stall_fields_held", {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata}, prev_fields);
      end
      icb_rsp_valid = 1'b0;
      icb_rsp_err   = 1'b0;
      icb_rsp_rdata = '0;
      if (have_cmd) begin
        if (rsp_wait > 0) rsp_wait--;
        else begin
          check("rsp_ready", icb_rsp_ready, 1'b1);
          icb_rsp_valid = 1'b1;
          if (cur_read) begin
            rd_count++;
            icb_rsp_rdata = mem.exists(cur_addr) ? mem[cur_addr] : 32'hBAD0_0000;
            icb_rsp_err   = (rd_count == err_read_idx);
          end
          have_cmd = 0;
        end
      end
      icb_cmd_ready = 1'b0;
      stalled_prev  = 0;
      if (icb_cmd_valid) begin
        if (stall_left > 0 || (rand_ready && $urandom_range(0, 3) == 0)) begin
          if (stall_left > 0) stall_left--;
          stalled_prev = 1;
          prev_fields  = {icb_cmd_read, icb_cmd_addr, icb_cmd_wdata};
        end else begin
          icb_cmd_ready = 1'b1;
          check("wmask", icb_cmd_wmask, 4'hF);
          check("cmd_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0)
            check("cmd_stream", {icb_cmd_read, icb_cmd_addr, icb_cmd_read ? 32'h0 : icb_cmd_wdata},
                  exp_q.pop_front());
          have_cmd = 1;
          cur_read = icb_cmd_read;
          cur_addr = icb_cmd_addr;
          if (!icb_cmd_read) wr_accepts++;
          rsp_wait = $urandom_range(min_delay, max_delay);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     busy, 1'b0);
    check({tag, "_done"},     done_irq, 1'b0);
    check({tag, "_err"},      err, 1'b0);
    check({tag, "_cvalid"},   icb_cmd_valid, 1'b0);
    check({tag, "_caddr"},    icb_cmd_addr, 32'h0);
    check({tag, "_cread"},    icb_cmd_read, 1'b0);
    check({tag, "_cwdata"},   icb_cmd_wdata, 32'h0);
    check({tag, "_cwmask"},   icb_cmd_wmask, 4'hF);
    check({tag, "_rsprdy"},   icb_rsp_ready, 1'b0);
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int n,
                          input int stall, input int dmin, input int dmax,
                          input int err_idx, input bit rnd_ready, input bit poke);
    bit done_seen;
    bit exp_err;
    for (int i = 0; i < n; i++) mem[src + 32'(4 * i)] = $urandom;
    build_exp(src, dst, n, err_idx);
    stall_left   = stall;
    min_delay    = dmin;
    max_delay    = dmax;
    err_read_idx = err_idx;
    rand_ready   = rnd_ready;
    rd_count     = 0;
    wr_accepts   = 0;
    exp_err      = (err_idx > 0) && (err_idx <= n);
    step();
    start = 1'b1; src_addr = src; dst_addr = dst; len = LEN_W'(n);
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    if (n == 0) begin
      check("len0_done_next", done_irq, 1'b1);
      check("len0_no_cmd", icb_cmd_valid, 1'b0);
    end else begin
      check("first_cmd_latency", {icb_cmd_valid, icb_cmd_read, icb_cmd_addr}, {2'b11, src});
    end
    done_seen = 0;
    for (int c = 0; c < 3000 && !done_seen; c++) begin
      start = 1'b0;
      if (done_irq) done_seen = 1;
      else begin
        if (poke && c == 2) begin
          start = 1'b1; src_addr = $urandom; dst_addr = $urandom;
          len = LEN_W'($urandom_range(1, 9));
        end
        step();
      end
    end
    start = 1'b0;
    check("done_seen", done_seen, 1'b1);
    check("err_at_done", err, exp_err);
    check("cmds_remaining", exp_q.size(), 0);
    step();
    check("done_one_cycle", done_irq, 1'b0);
    check("busy_low_after_done", busy, 1'b0);
    check("err_sticky", err, exp_err);
  endtask

  initial begin
    logic [31:0] s;
    int          n;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic 3-word copy, always-ready, one-cycle responses
    run_xfer(32'h8000_0000, 32'h8000_0100, 3, 0, 0, 0, 0, 0, 0);
    // zero-length request
    run_xfer(32'h8000_0000, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0);
    // crosses a chunk boundary: R,R,R,R,W,W,W,W,R,W
    run_xfer(32'h8000_1000, 32'h8000_2000, 5, 0, 0, 0, 0, 0, 0);
    // stalled first read command and random response delays
    run_xfer(32'h1000_0040, 32'h2000_0000, 6, 5, 0, 3, 0, 0, 0);
    // bus error on the second read
    run_xfer(32'h3000_0000, 32'h3000_0800, 4, 0, 0, 1, 2, 0, 0);
    // next start clears err
    run_xfer(32'h3000_0100, 32'h3000_0900, 2, 0, 0, 1, 0, 0, 0);
    // address wrap-around
    run_xfer(32'hFFFF_FFF8, 32'h0000_2000, 4, 0, 0, 2, 0, 1, 0);
    // randomized copies
    for (int t = 0; t < 5; t++) begin
      s = $urandom & 32'hFFFF_FFFC;
      n = $urandom_range(1, 11);
      run_xfer(s, s + 32'h0001_0000, n, $urandom_range(0, 3), 0, 3, 0, 1, 0);
    end

    // reset while waiting on a write response
    for (int i = 0; i < 4; i++) mem[32'h4000_0000 + 32'(4 * i)] = $urandom;
    build_exp(32'h4000_0000, 32'h4000_1000, 4, 0);
    stall_left = 0; min_delay = 3; max_delay = 3; err_read_idx = 0;
    rand_ready = 0; rd_count = 0; wr_accepts = 0;
    step();
    start = 1'b1; src_addr = 32'h4000_0000; dst_addr = 32'h4000_1000; len = LEN_W'(4);
    step();
    start = 1'b0;
    for (int c = 0; c < 500 && wr_accepts == 0; c++) step();
    check("reached_write", wr_accepts != 0, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    have_cmd = 0; stalled_prev = 0; exp_q.delete();
    icb_cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_err = 1'b0; icb_rsp_rdata = '0;
    step();
    check("reset_hold_done", done_irq, 1'b0);
    check("reset_hold_valid", icb_cmd_valid, 1'b0);
    rst_n = 1'b1;
    // single-word copy with a start pulse while busy
    run_xfer(32'h5000_0000, 32'h5000_0040, 1, 0, 1, 3, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
